// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: gap/on slot timing per digit,
// frame-synchronous shadow capture of the digit data, registered active-low drives.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1,
  parameter int GAP_CYCLES   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int MAX_CYC = (GAP_CYCLES > DWELL_CYCLES) ? GAP_CYCLES : DWELL_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_TOP    = IW'(NUM_DIGITS - 1);

  typedef enum logic {PH_GAP, PH_ON} phase_e;

  phase_e                  phase_q, phase_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] dig_q;
  logic [NUM_DIGITS-1:0]   dpm_q;
  logic [NUM_DIGITS-1:0]   blk_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    fd_q;

  logic [3:0] cur_dig;
  logic       cur_dp;
  logic       cur_blk;
  logic       gap0;
  logic       cap;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // The state registers name the slot position that the next enabled edge emits.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cur_dig = dig_q[{idx_q, 2'b00} +: 4];
    cur_dp  = dpm_q[idx_q];
    cur_blk = blk_q[idx_q];
    gap0    = (phase_q == PH_GAP) && (cnt_q == '0);
    cap     = gap0 && (idx_q == IDX_TOP);
    if (phase_q == PH_GAP) begin
      if (cnt_q == GAP_LAST) begin
        phase_d = PH_ON;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      if (cnt_q == DWELL_LAST) begin
        phase_d = PH_GAP;
        cnt_d   = '0;
        idx_d   = (idx_q == '0) ? IDX_TOP : idx_q - IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_GAP;
      cnt_q   <= '0;
      idx_q   <= IDX_TOP;
      dig_q   <= '0;
      dpm_q   <= '0;
      blk_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else if (!enable) begin
      an_q <= '1;
      fd_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (cap) begin
        dig_q <= digits_in;
        dpm_q <= dp_in;
        blk_q <= blank_in;
      end
      an_q <= '1;
      fd_q <= 1'b0;
      // Gap cycle 0 keeps the previous pattern so segments never change under a lit anode.
      if (!gap0) begin
        seg_q <= seg7(cur_dig);
        dp_q  <= ~cur_dp;
      end
      if (phase_q == PH_ON) begin
        if (!cur_blk) an_q <= ~(NUM_DIGITS'(1) << idx_q);
        fd_q <= (cnt_q == DWELL_LAST) && (idx_q == '0);
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: default build checked through a scoreboard fed by a
// reference table and a slot-arithmetic model; a wide build checked for timing invariants.
module tb_seg_scan_ctrl;

  localparam int N = 4, G = 3, D = 1;
  localparam int N8 = 8, G8 = 2, D8 = 5;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  typedef struct {
    logic       en;
    logic [15:0] dig;
    logic [3:0] dpi;
    logic [3:0] blk;
    exp_t       e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] dig = '0;
  logic [3:0]  dpi = '0;
  logic [3:0]  blk = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        fd;

  logic        reset8 = 1'b1;
  logic [31:0] dig8 = 32'h7654_3210;
  logic [7:0]  an8;
  logic [6:0]  seg8;
  logic        dp8;
  logic        fd8;

  int total = 0;
  int bad = 0;

  exp_t sbq[$];
  vec_t tab[16];

  int          m_e;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_blk;
  logic [6:0]  m_seg;
  logic        m_dpo;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .enable(en), .digits_in(dig), .dp_in(dpi),
    .blank_in(blk), .an(an), .seg(seg), .dp(dp), .frame_done(fd));

  seg_scan_ctrl #(.NUM_DIGITS(N8), .DWELL_CYCLES(D8), .GAP_CYCLES(G8)) dut8 (
    .clk(clk), .reset(reset8), .enable(1'b1), .digits_in(dig8), .dp_in(8'h00),
    .blank_in(8'h00), .an(an8), .seg(seg8), .dp(dp8), .frame_done(fd8));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_e = 0; m_dig = '0; m_dp = '0; m_blk = '0; m_seg = 7'h7F; m_dpo = 1'b1;
  endtask

  // Expected outputs for the edge about to happen, from the enabled-edge count.
  task automatic model_step(output exp_t r);
    int w, slot, idx;
    r.an = 4'hF; r.fd = 1'b0;
    if (en) begin
      w    = m_e % (G + D);
      slot = m_e / (G + D);
      idx  = N - 1 - (slot % N);
      if (w == 0 && idx == N - 1) begin
        m_dig = dig; m_dp = dpi; m_blk = blk;
      end
      if (w >= G && !m_blk[idx]) r.an[idx] = 1'b0;
      if (w != 0) begin
        m_seg = dec_tab[m_dig[4*idx +: 4]];
        m_dpo = ~m_dp[idx];
      end
      r.fd = (idx == 0) && (w == G + D - 1);
      m_e++;
    end
    r.seg = m_seg;
    r.dp  = m_dpo;
  endtask

  task automatic check_pop(input string nm);
    exp_t r;
    if (sbq.size() == 0) begin
      check({nm, "_underflow"}, 32'd0, 32'd1);
    end else begin
      r = sbq.pop_front();
      check(nm, {20'd0, an, seg, dp, fd}, {20'd0, r});
    end
  endtask

  task automatic run_model(input string nm, input int n);
    exp_t r;
    for (int i = 0; i < n; i++) begin
      model_step(r);
      sbq.push_back(r);
      @(posedge clk);
      @(negedge clk);
      check_pop(nm);
    end
  endtask

  task automatic run_table();
    exp_t r;
    for (int i = 0; i < 16; i++) begin
      en = tab[i].en; dig = tab[i].dig; dpi = tab[i].dpi; blk = tab[i].blk;
      model_step(r);
      sbq.push_back(tab[i].e);
      @(posedge clk);
      @(negedge clk);
      check_pop($sformatf("tab%0d", i));
    end
  endtask

  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] a, input logic [6:0] s,
                              input logic f);
    vec_t v;
    v.en = 1'b1; v.dig = d; v.dpi = 4'h0; v.blk = 4'h0;
    v.e.an = a; v.e.seg = s; v.e.dp = 1'b1; v.e.fd = f;
    return v;
  endfunction

  initial begin
    exp_t r;
    int last_fd, runlen[8];
    logic [7:0] an8_prev;
    logic [6:0] seg8_prev;
    bit got_on;

    // First frame after reset; digits switch to ABCD mid-frame without visible effect.
    tab[0]  = mk(16'h1234, 4'hF, 7'h7F, 1'b0);
    tab[1]  = mk(16'h1234, 4'hF, 7'h79, 1'b0);
    tab[2]  = mk(16'h1234, 4'hF, 7'h79, 1'b0);
    tab[3]  = mk(16'h1234, 4'h7, 7'h79, 1'b0);
    tab[4]  = mk(16'h1234, 4'hF, 7'h79, 1'b0);
    tab[5]  = mk(16'h1234, 4'hF, 7'h24, 1'b0);
    tab[6]  = mk(16'hABCD, 4'hF, 7'h24, 1'b0);
    tab[7]  = mk(16'hABCD, 4'hB, 7'h24, 1'b0);
    tab[8]  = mk(16'hABCD, 4'hF, 7'h24, 1'b0);
    tab[9]  = mk(16'hABCD, 4'hF, 7'h30, 1'b0);
    tab[10] = mk(16'hABCD, 4'hF, 7'h30, 1'b0);
    tab[11] = mk(16'hABCD, 4'hD, 7'h30, 1'b0);
    tab[12] = mk(16'hABCD, 4'hF, 7'h30, 1'b0);
    tab[13] = mk(16'hABCD, 4'hF, 7'h19, 1'b0);
    tab[14] = mk(16'hABCD, 4'hF, 7'h19, 1'b0);
    tab[15] = mk(16'hABCD, 4'hE, 7'h19, 1'b1);

    repeat (2) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dpfd", {30'd0, dp, fd}, 32'h2);
    reset = 1'b0;
    model_reset();

    run_table();
    run_model("frame2_abcd", 16);

    dig = 16'h1234; blk = 4'b0100; dpi = 4'b0001;
    run_model("blank_dp", 40);

    blk = 4'h0; dpi = 4'h0;
    for (int i = 0; i < 32; i++) begin
      if (((m_e % (G + D)) == G) && (N - 1 - ((m_e / (G + D)) % N) == 1)) break;
      run_model("seek_d1", 1);
    end
    en = 1'b0;
    run_model("en_low", 3);
    en = 1'b1;
    run_model("resume", 40);

    got_on = 1'b0;
    for (int i = 0; i < 20 && !got_on; i++) begin
      model_step(r);
      sbq.push_back(r);
      @(posedge clk);
      @(negedge clk);
      check_pop("pre_rst");
      got_on = (r.an != 4'hF);
    end
    #2 reset = 1'b1;
    #1;
    check("arst_an", {28'd0, an}, 32'hF);
    check("arst_seg", {25'd0, seg}, 32'h7F);
    check("arst_dpfd", {30'd0, dp, fd}, 32'h2);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_table();

    // Wide build: frame length, anode dwell and segment stability.
    reset8 = 1'b0;
    last_fd = -1;
    an8_prev = 8'hFF;
    seg8_prev = 7'h7F;
    for (int k = 0; k < 8; k++) runlen[k] = 0;
    for (int c = 0; c < 3 * N8 * (G8 + D8); c++) begin
      @(negedge clk);
      if (fd8) begin
        if (last_fd >= 0) check("w8_frame", c - last_fd, N8 * (G8 + D8));
        last_fd = c;
      end
      for (int k = 0; k < 8; k++) begin
        if (!an8[k]) runlen[k]++;
        else if (runlen[k] != 0) begin
          check($sformatf("w8_dwell%0d", k), runlen[k], D8);
          runlen[k] = 0;
        end
      end
      if (seg8 != seg8_prev) check("w8_segchg", {an8_prev, an8}, 16'hFFFF);
      an8_prev = an8;
      seg8_prev = seg8;
    end
    check("w8_seen", (last_fd >= 0) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
